nist_test_sequencer: RTL and testbench
======================================

Name: nist_test_sequencer

Overview:
- Run controller for the bank of NIST randomness test engines (runs, frequency, block tests).
- Flushes the engines, then forwards a fixed-length window of qualified random bits.
- Collects the engines' error flags into sticky per-test status and hands one result word per run to the host over a valid/ready handshake.
- Sits between the TRNG bit source and the test engines.

Parameters:
N_TESTS, 4, number of attached test engines (1..8)
SEQ_BITS, 14, run length is 2^SEQ_BITS qualified bits (default 16384 = 128 blocks x 128 bits)
FLUSH_CYCLES, 2, cycles engine reset is held low before each run (1..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  pulse; begins a run from IDLE, ignored elsewhere
cont  in  1  continuous mode; sampled in REPORT at handshake
abort  in  1  stops any run, returns to IDLE, no report
test_en  in  N_TESTS  per-test enable, sampled at FLUSH entry
rnd_in  in  1  random bit from source
rnd_valid  in  1  rnd_in qualifier
eng_rstn  out  N_TESTS  active-low engine reset
eng_bit  out  1  registered copy of rnd_in
eng_bit_en  out  1  registered rnd_valid & RUN; engine clock-enable
test_error  in  N_TESTS  engine error flags
busy  out  1  high in FLUSH, RUN, SNAP
res_valid  out  1  result available
res_ready  in  1  host accepts result
res_err  out  N_TESTS  sticky error mask of the run (masked tests read 0)
res_seq  out  8  run sequence number
fail_any  out  1  OR of res_err, valid with res_valid

Behaviour:
- Reset (rst high, async): state IDLE, eng_rstn all 0, eng_bit 0, eng_bit_en 0, busy 0, res_valid 0, res_err 0, res_seq 0, fail_any 0; bit counter, flush counter and sticky register cleared.
- FSM states: IDLE, FLUSH, RUN, SNAP, REPORT.
- IDLE:
  - eng_rstn all 0.
  - start=1 -> FLUSH; test_en latched into en_q.
- FLUSH:
  - eng_rstn all 0; flush counter counts FLUSH_CYCLES cycles, then -> RUN.
  - Sticky register and bit counter cleared on entry.
- RUN:
  - eng_rstn = en_q; disabled engines stay in reset.
  - Each cycle: eng_bit <= rnd_in, eng_bit_en <= rnd_valid (one-cycle latency).
  - Bit counter (SEQ_BITS+1 wide) increments on rnd_valid.
  - sticky[i] |= test_error[i] & en_q[i], every cycle.
  - When the count reaches 2^SEQ_BITS (the last bit forwarded) -> SNAP. rnd_valid is ignored from that cycle on.
- SNAP (1 cycle):
  - Final sticky OR, including test_error of the cycle after the last bit.
  - Then -> REPORT.
  - eng_bit_en 0; engines remain out of reset.
- REPORT:
  - res_valid=1; res_err=sticky; fail_any=|sticky.
  - Outputs stable until res_valid & res_ready.
  - On handshake: res_seq increments (wraps 255->0), res_valid drops next cycle.
  - Next state: FLUSH if cont=1 (en_q re-latched), else IDLE.
  - Bits arriving in REPORT are dropped; the engines see no eng_bit_en.
- abort:
  - Highest priority over start and handshake, from any state.
  - -> IDLE next cycle; res_valid 0, sticky cleared, res_seq unchanged.
- Simultaneous events:
  - start and abort in IDLE: stay IDLE.
  - res_ready without res_valid: ignored.
- test_en all zero is legal: run completes, res_err=0.
- busy = state in {FLUSH, RUN, SNAP}.

Decomposition:
- Shared package nist_pkg:
  - state enum encoding (IDLE=0, FLUSH=1, RUN=2, SNAP=3, REPORT=4)
  - RES_SEQ_W=8
  - default SEQ_BITS
- Sub-module: nist_sticky_status.
  - N_TESTS sticky flags with clear, enable mask and OR-reduce.
  - Instantiated once.
- Bit and flush counters are inline.

Test Plan (SEQ_BITS=4, FLUSH_CYCLES=2, N_TESTS=4):
1. Basic run:
   - rst, then start with test_en=4'b1111 and 16 valid bits, no errors.
   - Expect: eng_rstn low exactly 2 cycles after start; 16 eng_bit_en pulses; res_valid with res_err=0, fail_any=0, res_seq=0; after handshake, IDLE with busy=0.
2. Error capture:
   - test_error[2] pulsed for 1 cycle mid-run, test_error[0] asserted in the SNAP cycle.
   - Expect: res_err=4'b0101, fail_any=1.
   - test_error[3] asserted while test_en[3]=0: masked, eng_rstn[3] stays 0 throughout.
3. Gapped input:
   - rnd_valid duty 1/3 with a data pattern 1010...
   - Expect: exactly 16 eng_bit_en pulses; eng_bit matches rnd_in delayed by 1 cycle; RUN is exited only after the 16th valid bit.
4. Back-pressure and continuous mode:
   - res_ready held low 10 cycles, cont=1.
   - Expect: res_err and res_seq stable throughout; handshake -> FLUSH; three runs give res_seq 0,1,2.
   - Then 256 runs: res_seq wraps to 0.
5. Abort and reset:
   - abort after 7 bits: IDLE next cycle, no res_valid, res_seq unchanged; a following start runs a full 16 bits.
   - rst asserted mid-RUN: all outputs at reset values immediately (async), without a clock edge.

Source files
------------

// File: rtl/nist_pkg.sv
// Shared types and constants for the NIST test sequencer.
package nist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_RUN    = 3'd2,
    ST_SNAP   = 3'd3,
    ST_REPORT = 3'd4
  } state_e;

  localparam int RES_SEQ_W        = 8;
  localparam int SEQ_BITS_DEFAULT = 14;

endpackage

// File: rtl/nist_sticky_status.sv
// Sticky per-test error flags: clear wins over capture, capture ORs in masked errors.
module nist_sticky_status #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         cap_i,
  input  logic [N-1:0] mask_i,
  input  logic [N-1:0] err_i,
  output logic [N-1:0] flags_o,
  output logic         any_o
);

  logic [N-1:0] flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (clr_i) begin
      flags_d = '0;
    end else if (cap_i) begin
      flags_d = flags_q | (err_i & mask_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags_o = flags_q;
  assign any_o   = |flags_q;

endmodule

// File: rtl/nist_test_sequencer.sv
// Run controller for the NIST test engines: flush, forward 2^SEQ_BITS qualified bits,
// then present one sticky error word per run to the host over valid/ready.
module nist_test_sequencer
  import nist_pkg::*;
#(
  parameter int N_TESTS      = 4,
  parameter int SEQ_BITS     = SEQ_BITS_DEFAULT,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cont,
  input  logic                 abort,
  input  logic [N_TESTS-1:0]   test_en,
  input  logic                 rnd_in,
  input  logic                 rnd_valid,
  output logic [N_TESTS-1:0]   eng_rstn,
  output logic                 eng_bit,
  output logic                 eng_bit_en,
  input  logic [N_TESTS-1:0]   test_error,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [N_TESTS-1:0]   res_err,
  output logic [RES_SEQ_W-1:0] res_seq,
  output logic                 fail_any
);

  localparam logic [SEQ_BITS:0] LAST_M1    = {1'b0, {SEQ_BITS{1'b1}}};
  localparam logic [3:0]        FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_e                 state_q;
  logic [N_TESTS-1:0]     en_q;
  logic [N_TESTS-1:0]     eng_rstn_q;
  logic                   eng_bit_q;
  logic                   eng_bit_en_q;
  logic                   res_valid_q;
  logic [RES_SEQ_W-1:0]   res_seq_q;
  logic [SEQ_BITS:0]      bit_cnt_q;
  logic [3:0]             flush_cnt_q;

  logic                   hs;
  logic                   flush_entry;
  logic                   sticky_clr;
  logic                   sticky_cap;
  logic [N_TESTS-1:0]     sticky;
  logic                   sticky_any;

  assign hs          = (state_q == ST_REPORT) & res_valid_q & res_ready;
  assign flush_entry = ~abort & (((state_q == ST_IDLE) & start) | (hs & cont));
  assign sticky_clr  = abort | flush_entry;
  // SNAP is included so an error raised on the cycle after the last bit still counts.
  assign sticky_cap  = (state_q == ST_RUN) | (state_q == ST_SNAP);

  nist_sticky_status #(.N(N_TESTS)) u_sticky (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (sticky_clr),
    .cap_i   (sticky_cap),
    .mask_i  (en_q),
    .err_i   (test_error),
    .flags_o (sticky),
    .any_o   (sticky_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      en_q         <= '0;
      eng_rstn_q   <= '0;
      eng_bit_q    <= 1'b0;
      eng_bit_en_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_seq_q    <= '0;
      bit_cnt_q    <= '0;
      flush_cnt_q  <= '0;
    end else begin
      eng_bit_q    <= rnd_in;
      eng_bit_en_q <= 1'b0;
      if (abort) begin
        state_q     <= ST_IDLE;
        eng_rstn_q  <= '0;
        res_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q     <= ST_FLUSH;
              en_q        <= test_en;
              flush_cnt_q <= '0;
              bit_cnt_q   <= '0;
            end
          end
          ST_FLUSH: begin
            if (flush_cnt_q == FLUSH_LAST) begin
              state_q    <= ST_RUN;
              eng_rstn_q <= en_q;
            end else begin
              flush_cnt_q <= flush_cnt_q + 4'd1;
            end
          end
          ST_RUN: begin
            if (rnd_valid) begin
              eng_bit_en_q <= 1'b1;
              bit_cnt_q    <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == LAST_M1) begin
                state_q <= ST_SNAP;
              end
            end
          end
          ST_SNAP: begin
            state_q     <= ST_REPORT;
            res_valid_q <= 1'b1;
          end
          ST_REPORT: begin
            if (hs) begin
              res_valid_q <= 1'b0;
              res_seq_q   <= res_seq_q + 1'b1;
              eng_rstn_q  <= '0;
              if (cont) begin
                state_q     <= ST_FLUSH;
                en_q        <= test_en;
                flush_cnt_q <= '0;
                bit_cnt_q   <= '0;
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign eng_rstn   = eng_rstn_q;
  assign eng_bit    = eng_bit_q;
  assign eng_bit_en = eng_bit_en_q;
  assign busy       = (state_q == ST_FLUSH) | (state_q == ST_RUN) | (state_q == ST_SNAP);
  assign res_valid  = res_valid_q;
  assign res_err    = res_valid_q ? sticky : '0;
  assign res_seq    = res_seq_q;
  assign fail_any   = res_valid_q & sticky_any;

endmodule

// File: tb/tb_nist_test_sequencer.sv
// Directed bench for nist_test_sequencer with SEQ_BITS=4, FLUSH_CYCLES=2, N_TESTS=4.
module tb_nist_test_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, cont, abort;
  logic [3:0] test_en;
  logic       rnd_in, rnd_valid;
  logic [3:0] eng_rstn;
  logic       eng_bit, eng_bit_en;
  logic [3:0] test_error;
  logic       busy, res_valid, res_ready;
  logic [3:0] res_err;
  logic [7:0] res_seq;
  logic       fail_any;

  int n_tests = 0;
  int n_fail  = 0;

  nist_test_sequencer #(.N_TESTS(4), .SEQ_BITS(4), .FLUSH_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cont       (cont),
    .abort      (abort),
    .test_en    (test_en),
    .rnd_in     (rnd_in),
    .rnd_valid  (rnd_valid),
    .eng_rstn   (eng_rstn),
    .eng_bit    (eng_bit),
    .eng_bit_en (eng_bit_en),
    .test_error (test_error),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_err    (res_err),
    .res_seq    (res_seq),
    .fail_any   (fail_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic pat(input int k);
    pat = ~k[0];
  endfunction

  task automatic do_start(input logic [3:0] en);
    test_en = en;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Entered on the negedge just after the FLUSH-entry edge; leaves in REPORT.
  task automatic run_window(input logic [3:0] en, input int gap, input logic [3:0] err_bg,
                            input logic [3:0] err_mid, input logic [3:0] err_snap);
    int cnt;
    int bad;
    cnt = 0;
    bad = 0;
    chk("flush_rstn0", 32'(eng_rstn), 32'h0);
    chk("flush_busy", 32'(busy), 32'h1);
    test_error = err_bg;
    tick();
    chk("flush_rstn1", 32'(eng_rstn), 32'h0);
    tick();
    chk("run_rstn", 32'(eng_rstn), 32'(en));
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          rnd_valid  = 1'b0;
          rnd_in     = ~pat(k);
          test_error = err_bg;
          tick();
          cnt += int'(eng_bit_en);
        end
      end
      rnd_valid  = 1'b1;
      rnd_in     = pat(k);
      test_error = err_bg | ((k == 8) ? err_mid : 4'b0000);
      tick();
      cnt += int'(eng_bit_en);
      if (!eng_bit_en || eng_bit !== pat(k)) bad++;
    end
    chk("snap_busy", 32'(busy), 32'h1);
    chk("snap_noval", 32'(res_valid), 32'h0);
    rnd_valid  = 1'b1;
    rnd_in     = 1'b1;
    test_error = err_bg | err_snap;
    tick();
    cnt += int'(eng_bit_en);
    test_error = err_bg;
    tick();
    cnt += int'(eng_bit_en);
    rnd_valid  = 1'b0;
    test_error = 4'b0000;
    chk("pulses", 32'(cnt), 32'd16);
    chk("bitdata", 32'(bad), 32'd0);
    chk("rep_busy", 32'(busy), 32'h0);
    chk("rep_rstn", 32'(eng_rstn), 32'(en));
  endtask

  task automatic expect_result(input logic [3:0] err, input int seq);
    chk("res_valid", 32'(res_valid), 32'h1);
    chk("res_err", 32'(res_err), 32'(err));
    chk("fail_any", 32'(fail_any), 32'(|err));
    chk("res_seq", 32'(res_seq), 32'(seq & 255));
  endtask

  task automatic handshake(input logic c, input int seq);
    cont      = c;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("hs_valid", 32'(res_valid), 32'h0);
    chk("hs_seq", 32'(res_seq), 32'((seq + 1) & 255));
    chk("hs_busy", 32'(busy), 32'(c));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0; test_en = 4'hF;
    rnd_in = 1'b0; rnd_valid = 1'b0; test_error = 4'h0; res_ready = 1'b0;
    tick();
    chk("rst_rstn", 32'(eng_rstn), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", 32'(res_valid), 32'h0);
    chk("rst_seq", 32'(res_seq), 32'h0);
    chk("rst_bit_en", 32'(eng_bit_en), 32'h0);
    rst = 1'b0;
    tick();

    // Basic run
    do_start(4'b1111);
    run_window(4'b1111, 0, 4'b0000, 4'b0000, 4'b0000);
    expect_result(4'b0000, 0);
    handshake(1'b0, 0);

    // Error capture: mid-run pulse on [2], SNAP-cycle error on [0], masked [3]
    do_start(4'b0111);
    run_window(4'b0111, 0, 4'b1000, 4'b0100, 4'b0001);
    expect_result(4'b0101, 1);
    handshake(1'b0, 1);

    // Gapped input, duty 1/3
    do_start(4'b1111);
    run_window(4'b1111, 2, 4'b0000, 4'b0000, 4'b0000);
    expect_result(4'b0000, 2);
    handshake(1'b0, 2);

    // Abort after 7 bits
    do_start(4'b1111);
    test_error = 4'b0010;
    tick();
    tick();
    for (int k = 0; k < 7; k++) begin
      rnd_valid = 1'b1;
      rnd_in    = pat(k);
      tick();
    end
    rnd_valid = 1'b0;
    abort     = 1'b1;
    tick();
    abort     = 1'b0;
    test_error = 4'b0000;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_valid", 32'(res_valid), 32'h0);
    chk("abort_rstn", 32'(eng_rstn), 32'h0);
    chk("abort_seq", 32'(res_seq), 32'd3);
    tick(); tick(); tick();
    chk("abort_novalid", 32'(res_valid), 32'h0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 32'(busy), 32'h0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("ready_idle_seq", 32'(res_seq), 32'd3);
    do_start(4'b1111);
    run_window(4'b1111, 0, 4'b0000, 4'b0000, 4'b0000);
    expect_result(4'b0000, 3);
    handshake(1'b0, 3);

    // Back-pressure and continuous mode from a fresh reset, 257 runs
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_seq", 32'(res_seq), 32'h0);
    test_en = 4'b1011;
    cont    = 1'b1;
    for (int i = 0; i <= 256; i++) begin
      if (i == 0) do_start(4'b1011);
      run_window(4'b1011, 0, 4'b0000, (i == 1) ? 4'b0010 : 4'b0000, 4'b0000);
      expect_result((i == 1) ? 4'b0010 : 4'b0000, i);
      if (i == 0) begin
        for (int w = 0; w < 10; w++) begin
          tick();
          chk("bp_valid", 32'(res_valid), 32'h1);
          chk("bp_err", 32'(res_err), 32'h0);
          chk("bp_seq", 32'(res_seq), 32'h0);
        end
      end
      handshake((i == 256) ? 1'b0 : 1'b1, i);
    end

    // Async reset mid-RUN
    do_start(4'b1111);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      rnd_valid = 1'b1;
      rnd_in    = 1'b1;
      tick();
    end
    chk("pre_rst_bit", 32'(eng_bit), 32'h1);
    chk("pre_rst_rstn", 32'(eng_rstn), 32'hF);
    #2 rst = 1'b1;
    #1;
    chk("arst_rstn", 32'(eng_rstn), 32'h0);
    chk("arst_bit", 32'(eng_bit), 32'h0);
    chk("arst_bit_en", 32'(eng_bit_en), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_valid", 32'(res_valid), 32'h0);
    chk("arst_seq", 32'(res_seq), 32'h0);
    chk("arst_err", 32'(res_err), 32'h0);
    chk("arst_fail", 32'(fail_any), 32'h0);
    rnd_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
